// File: rtl/ifetch_queue.sv
// Decoupled instruction-fetch queue: issues in-order word fetches, buffers
// {pc, instr} pairs in a small FIFO and flushes on control-flow redirects.
module ifetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = CW + 1;
  localparam logic [CW:0] DEPTH_S = SW'(DEPTH);

  typedef enum logic {FETCH, FLUSH} state_t;

  state_t          state, state_next;
  logic [31:0]     fetch_pc, rsp_pc;
  logic [CW-1:0]   outstanding, discard, discard_next, redirect_discard;
  logic [CW-1:0]   count;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [31:0]     pc_mem    [DEPTH];
  logic [31:0]     instr_mem [DEPTH];
  logic [31:0]     last_pc, last_instr;
  logic            accept, rsp_fire, push, pop;

  always_comb begin
    mem_req_valid = (state == FETCH) && (({1'b0, count} + {1'b0, outstanding}) < DEPTH_S) && !rst;
    mem_req_addr  = fetch_pc;
    accept        = mem_req_valid && mem_req_ready;
    // A beat with nothing outstanding is a protocol error and is ignored.
    rsp_fire      = mem_rsp_valid && (outstanding != '0);
    push          = rsp_fire && (discard == '0) && !redirect;
    out_valid     = (count != '0);
    pop           = out_valid && out_ready;
    out_pc        = out_valid ? pc_mem[rd_ptr]    : last_pc;
    out_instr     = out_valid ? instr_mem[rd_ptr] : last_instr;
    redirect_discard = outstanding + CW'(accept) - CW'(rsp_fire);
  end

  always_comb begin
    state_next   = state;
    discard_next = discard;
    if (redirect) begin
      discard_next = redirect_discard;
      state_next   = (redirect_discard != '0) ? FLUSH : FETCH;
    end else if (rsp_fire && (discard != '0)) begin
      discard_next = discard - CW'(1);
      if (discard == CW'(1)) state_next = FETCH;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH;
      discard     <= '0;
      outstanding <= '0;
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      last_pc     <= '0;
      last_instr  <= '0;
    end else begin
      state       <= state_next;
      discard     <= discard_next;
      outstanding <= outstanding + CW'(accept) - CW'(rsp_fire);
      // Shadow of the head so outputs hold the last presented entry once empty.
      if (out_valid) begin
        last_pc    <= pc_mem[rd_ptr];
        last_instr <= instr_mem[rd_ptr];
      end
      if (redirect) begin
        fetch_pc <= {redirect_pc[31:2], 2'b00};
        rsp_pc   <= {redirect_pc[31:2], 2'b00};
        count    <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
      end else begin
        if (accept) fetch_pc <= fetch_pc + 32'd4;
        if (push) begin
          rsp_pc <= rsp_pc + 32'd4;
          wr_ptr <= wr_ptr + PW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= rsp_pc;
      instr_mem[wr_ptr] <= mem_rsp_data;
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Scoreboard bench for ifetch_queue: a latency-programmable memory model
// feeds responses; accepted request addresses form the expected output stream.
module tb_ifetch_queue;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst, redirect, mem_req_valid, mem_req_ready, mem_rsp_valid;
  logic        out_valid, out_ready;
  logic [31:0] redirect_pc, mem_req_addr, mem_rsp_data, out_pc, out_instr;

  ifetch_queue #(.DEPTH(4), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data(mem_rsp_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } pend_t;

  pend_t       pend[$];
  logic [31:0] exp_q[$];
  logic [31:0] exp_addr;
  int          cyc, lat;
  int          n_tests, n_fail;
  int          n_acc, n_pop, first_acc, first_ov;
  logic        s_reqv, s_ov, s_pop;
  logic [31:0] s_addr, s_pc;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input logic rdy, input logic ordy, input logic redir,
                      input logic [31:0] rpc, input logic r);
    logic        acc, rsp, pop, stale;
    logic [31:0] a;
    @(negedge clk);
    rst           = r;
    redirect      = redir;
    redirect_pc   = rpc;
    mem_req_ready = rdy;
    out_ready     = ordy;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = mdata(pend[0].addr);
    end else begin
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
    end
    #1;
    s_reqv = mem_req_valid;
    s_addr = mem_req_addr;
    s_ov   = out_valid;
    s_pc   = out_pc;
    acc    = mem_req_valid && mem_req_ready;
    rsp    = mem_rsp_valid;
    pop    = out_valid && out_ready;
    s_pop  = pop;
    if (r) begin
      check("rst_reqv", 32'(mem_req_valid), 0);
      pend.delete();
      exp_q.delete();
      exp_addr = RESET_PC;
    end else begin
      stale = 1'b0;
      foreach (pend[i]) if (pend[i].stale) stale = 1'b1;
      if (stale) check("flush_noreq", 32'(mem_req_valid), 0);
      if (pop) begin
        n_pop++;
        check("pop_pending", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          a = exp_q.pop_front();
          check("out_pc", out_pc, a);
          check("out_instr", out_instr, mdata(a));
        end
      end
      if (rsp) void'(pend.pop_front());
      if (acc) begin
        n_acc++;
        if (first_acc < 0) first_acc = cyc;
        check("req_addr", mem_req_addr, exp_addr);
        exp_addr += 32'd4;
        pend.push_back('{mem_req_addr, cyc + lat, redir});
        if (!redir) exp_q.push_back(mem_req_addr);
      end
      if (out_valid && first_ov < 0) first_ov = cyc;
      if (redir) begin
        foreach (pend[i]) pend[i].stale = 1'b1;
        exp_q.delete();
        exp_addr = {rpc[31:2], 2'b00};
      end
    end
    @(posedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b0, 1'b0, '0, 1'b1);
    first_acc = -1; first_ov = -1; n_acc = 0; n_pop = 0;
  endtask

  task automatic drain();
    repeat (12) step(1'b0, 1'b1, 1'b0, '0, 1'b0);
    check("drained", 32'(exp_q.size()), 0);
    check("mem_idle", 32'(pend.size()), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0; lat = 1;
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; mem_req_ready = 1'b0;
    out_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    exp_addr = RESET_PC;

    // Reset state and steady streaming with 1-cycle memory.
    do_reset();
    #1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_pc", out_pc, 0);
    check("rst_out_instr", out_instr, 0);
    repeat (20) step(1'b1, 1'b1, 1'b0, '0, 1'b0);
    check("first_latency", 32'(first_ov - first_acc), 2);
    check("stream_acc", 32'(n_acc), 20);
    check("stream_pop", 32'(n_pop), 18);
    drain();

    // Consumer stalled: credits cap requests at DEPTH.
    do_reset();
    repeat (10) step(1'b1, 1'b0, 1'b0, '0, 1'b0);
    check("full_acc", 32'(n_acc), 4);
    check("full_reqv", 32'(s_reqv), 0);
    check("full_head", s_pc, 32'h0);
    step(1'b1, 1'b1, 1'b0, '0, 1'b0);
    check("resume_addr_full", s_addr, 32'h10);
    repeat (8) step(1'b1, 1'b1, 1'b0, '0, 1'b0);
    drain();

    // 3-cycle memory, 3 in flight at redirect.
    do_reset();
    lat = 3;
    repeat (2) step(1'b1, 1'b0, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 32'h100, 1'b0);
    repeat (3) step(1'b1, 1'b1, 1'b0, '0, 1'b0);
    check("flush_v", 32'(s_reqv), 0);
    step(1'b1, 1'b1, 1'b0, '0, 1'b0);
    check("flush_resume_v", 32'(s_reqv), 1);
    check("flush_resume_addr", s_addr, 32'h100);
    repeat (12) step(1'b1, 1'b1, 1'b0, '0, 1'b0);
    drain();

    // Redirect coinciding with a pop and a response beat.
    do_reset();
    lat = 1;
    repeat (2) step(1'b1, 1'b0, 1'b0, '0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 32'h203, 1'b0);
    check("redir_pop", 32'(s_pop), 1);
    step(1'b1, 1'b1, 1'b0, '0, 1'b0);
    check("redir_empty", 32'(s_ov), 0);
    step(1'b1, 1'b1, 1'b0, '0, 1'b0);
    check("redir_addr", s_addr, 32'h200);
    repeat (8) step(1'b1, 1'b1, 1'b0, '0, 1'b0);
    drain();

    // Two redirects one cycle apart; the 0x40 request is in flight at the second.
    do_reset();
    repeat (4) step(1'b1, 1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 32'h40, 1'b0);
    step(1'b1, 1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 32'h80, 1'b0);
    n_pop = 0;
    repeat (10) step(1'b1, 1'b1, 1'b0, '0, 1'b0);
    check("redir2_pops", 32'(n_pop > 0), 1);
    drain();

    // Reset wins over a simultaneous redirect with requests outstanding.
    do_reset();
    lat = 3;
    repeat (2) step(1'b1, 1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 32'h300, 1'b1);
    step(1'b1, 1'b1, 1'b0, '0, 1'b0);
    check("rst_mid_ov", 32'(s_ov), 0);
    check("rst_mid_reqv", 32'(s_reqv), 1);
    check("rst_mid_addr", s_addr, RESET_PC);
    repeat (10) step(1'b1, 1'b1, 1'b0, '0, 1'b0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
